// File: rtl/rgb_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb_mixer_pkg
// Description : Shared definitions for the RGB mixer slice.
//               - c_DEFAULT_WIDTH : default per-channel level width.
//               - fader_state_t   : sweep FSM state encoding for rgb_fader.
// Revision    : 1.0 - initial release
// ============================================================================
package rgb_mixer_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    // IDLE waits for a tick; CH0..CH2 update one channel each, one cycle apiece.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CH0  = 2'd1,
        ST_CH1  = 2'd2,
        ST_CH2  = 2'd3
    } fader_state_t;

endpackage : rgb_mixer_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Prescaler producing a one-cycle tick every TICK_DIV enabled
//               cycles. The count holds while enable is low.
// Ports       : clk    - rising-edge clock
//               reset  - synchronous, active-low
//               enable - advance the prescaler when high
//               tick   - high on the cycle the count wraps TICK_DIV-1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int              c_CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_CW'(1);
            end
        end
    end

    // Qualified by enable so a held count at the last value does not repeat ticks.
    assign tick = enable && (r_count == c_LAST);

endmodule : tick_gen
`default_nettype wire

// File: rtl/rgb_fader.sv
`default_nettype none
// ============================================================================
// Module      : rgb_fader
// Description : Three-channel level slew limiter. On each tick the targets are
//               snapshotted and each channel moves at most STEP toward its
//               snapshot, one channel per cycle, through a shared adder.
// Ports       : clk                     - rising-edge clock
//               reset                   - synchronous, active-low
//               enable                  - allow step ticks
//               target0/1/2 [WIDTH]     - requested levels
//               level0/1/2  [WIDTH]     - slewed levels (registered)
//               busy                    - sweep in progress (registered)
//               settled                 - all levels equal live targets (comb.)
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_fader
    import rgb_mixer_pkg::*;
#(
    parameter int WIDTH    = c_DEFAULT_WIDTH,
    parameter int TICK_DIV = 16,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] target0,
    input  logic [WIDTH-1:0] target1,
    input  logic [WIDTH-1:0] target2,
    output logic [WIDTH-1:0] level0,
    output logic [WIDTH-1:0] level1,
    output logic [WIDTH-1:0] level2,
    output logic             busy,
    output logic             settled
);

    // One extra bit so up-steps cannot overflow and down-steps expose a borrow.
    localparam logic [WIDTH:0] c_STEP_EXT = (WIDTH + 1)'(STEP);

    fader_state_t     r_state;
    fader_state_t     w_state_next;
    logic             w_tick;
    logic [WIDTH-1:0] r_snap0, r_snap1, r_snap2;
    logic [WIDTH-1:0] r_level0, r_level1, r_level2;
    logic             r_busy;
    logic [WIDTH-1:0] w_cur_snap;
    logic [WIDTH-1:0] w_cur_level;
    logic [WIDTH:0]   w_snap_ext;
    logic [WIDTH:0]   w_lvl_ext;
    logic [WIDTH:0]   w_up;
    logic [WIDTH:0]   w_dn;
    logic [WIDTH-1:0] w_new_level;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (w_tick)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_tick) w_state_next = ST_CH0;
            ST_CH0:  w_state_next = ST_CH1;
            ST_CH1:  w_state_next = ST_CH2;
            ST_CH2:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- shared step datapath ----------------
    always_comb begin
        w_cur_snap  = r_snap0;
        w_cur_level = r_level0;
        case (r_state)
            ST_CH1: begin
                w_cur_snap  = r_snap1;
                w_cur_level = r_level1;
            end
            ST_CH2: begin
                w_cur_snap  = r_snap2;
                w_cur_level = r_level2;
            end
            default: ;
        endcase
    end

    assign w_snap_ext = {1'b0, w_cur_snap};
    assign w_lvl_ext  = {1'b0, w_cur_level};
    assign w_up       = w_lvl_ext + c_STEP_EXT;
    assign w_dn       = w_lvl_ext - c_STEP_EXT;

    always_comb begin
        w_new_level = w_cur_level;
        if (w_snap_ext > w_lvl_ext) begin
            w_new_level = (w_up > w_snap_ext) ? w_cur_snap : w_up[WIDTH-1:0];
        end else if (w_snap_ext < w_lvl_ext) begin
            // A set MSB means the subtraction borrowed past zero.
            w_new_level = (w_dn[WIDTH] || (w_dn < w_snap_ext)) ? w_cur_snap
                                                                : w_dn[WIDTH-1:0];
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_snap0  <= '0;
            r_snap1  <= '0;
            r_snap2  <= '0;
            r_level0 <= '0;
            r_level1 <= '0;
            r_level2 <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            // Snapshot only when a sweep starts so mid-sweep target edits wait.
            if ((r_state == ST_IDLE) && w_tick) begin
                r_snap0 <= target0;
                r_snap1 <= target1;
                r_snap2 <= target2;
            end
            case (r_state)
                ST_CH0:  r_level0 <= w_new_level;
                ST_CH1:  r_level1 <= w_new_level;
                ST_CH2:  r_level2 <= w_new_level;
                default: ;
            endcase
        end
    end

    assign level0  = r_level0;
    assign level1  = r_level1;
    assign level2  = r_level2;
    assign busy    = r_busy;
    assign settled = (r_level0 == target0) && (r_level1 == target1) && (r_level2 == target2);

endmodule : rgb_fader
`default_nettype wire
